// File: rtl/bist_pkg.sv
// bist_pkg: shared state encoding and default sizing for the BIST sequencer.
package bist_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, COMPARE, DONE} state_e;
  localparam int SIG_WIDTH_DEF = 4;
  localparam int PATTERN_COUNT_DEF = 8;
endpackage

// File: rtl/bist_pattern_counter.sv
// bist_pattern_counter: counts applied patterns and flags the last one.
module bist_pattern_counter #(
  parameter int COUNT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic last_o
);
  localparam int CW = $clog2(COUNT + 1);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = clear_i ? '0 : enable_i ? count_q + CW'(1) : count_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  assign last_o = count_q == CW'(COUNT - 1);
endmodule

// File: rtl/bist_controller.sv
// bist_controller: sequences TPG and MISR through one BIST run and grades the signature.
module bist_controller
  import bist_pkg::*;
#(
  parameter int PATTERN_COUNT = PATTERN_COUNT_DEF,
  parameter int SIG_WIDTH = SIG_WIDTH_DEF,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SIG_WIDTH-1:0] signature,
  output logic                 ora_reset_n,
  output logic                 tpg_load,
  output logic                 tpg_enable,
  output logic                 test_mode,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [SIG_WIDTH-1:0] sig_captured
);
  state_e state_q, state_d;
  logic last;
  logic pass_q, pass_d, fail_q, fail_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  bist_pattern_counter #(.COUNT(PATTERN_COUNT)) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear_i (abort || state_q == CLEAR),
    .enable_i(state_q == RUN),
    .last_o  (last)
  );
  always_comb begin
    state_d = state_q;
    pass_d = pass_q;
    fail_d = fail_q;
    sig_d = sig_q;
    if (abort) begin
      state_d = IDLE;
      pass_d = 1'b0;
      fail_d = 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_d = start ? CLEAR : IDLE;
        CLEAR:   state_d = RUN;
        RUN:     state_d = last ? COMPARE : RUN;
        COMPARE: begin
          state_d = DONE;
          sig_d = signature;
          pass_d = signature == GOLDEN_SIG;
          fail_d = signature != GOLDEN_SIG;
        end
        DONE: if (start) begin
          state_d = CLEAR;
          pass_d = 1'b0;
          fail_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      sig_q <= '0;
    end else begin
      state_q <= state_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
      sig_q <= sig_d;
    end
  assign ora_reset_n = state_q != CLEAR;
  assign tpg_load = state_q == CLEAR;
  assign tpg_enable = state_q == RUN;
  assign test_mode = state_q inside {CLEAR, RUN, COMPARE};
  assign busy = state_q inside {CLEAR, RUN, COMPARE};
  assign done = state_q == DONE;
  assign pass = pass_q;
  assign fail = fail_q;
  assign sig_captured = sig_q;
endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Downstream consumer and sequencer for the 4-bit MISR output response analyser in the full-adder BIST chain.
- Clears the ORA, enables the test pattern generator for a fixed number of patterns, then captures the final MISR signature.
- Compares the captured signature with a golden value and reports pass/fail with a done flag.
- Top-level BIST wrapper instantiates it alongside the TPG, CUT mux and MISR.

Parameters:
- PATTERN_COUNT, 8, patterns applied per test run (exhaustive a/b/cin for 1-bit full adder); must be >= 1
- SIG_WIDTH, 4, MISR signature width
- GOLDEN_SIG, 4'b0000 (overridden at integration), fault-free signature

Ports:
- clock  input  1  system clock
- reset  input  1  reset, asynchronous, active-low
- start  input  1  begin test; sampled in IDLE or DONE only
- abort  input  1  synchronous abort to IDLE; priority over start
- signature  input  SIG_WIDTH  MISR dataout_ora
- ora_reset_n  output  1  active-low clear to MISR reset (ANDed with system reset at top level)
- tpg_load  output  1  load TPG seed
- tpg_enable  output  1  advance TPG one pattern per cycle
- test_mode  output  1  selects TPG patterns into CUT
- busy  output  1  high in CLEAR, RUN, COMPARE
- done  output  1  high in DONE
- pass  output  1  signature == GOLDEN_SIG; valid while done
- fail  output  1  signature != GOLDEN_SIG; valid while done
- sig_captured  output  SIG_WIDTH  signature latched in COMPARE

Behaviour:
- Reset: state IDLE, counter 0. busy, done, pass, fail, tpg_load, tpg_enable and test_mode are 0; ora_reset_n is 1; sig_captured is 0.
- FSM states: IDLE, CLEAR, RUN, COMPARE, DONE. All outputs decode from registered state; pass, fail and sig_captured are registers.
- IDLE: start=1 -> CLEAR.
- CLEAR, one cycle: ora_reset_n=0, tpg_load=1, test_mode=1; counter<=0 -> RUN.
- RUN: tpg_enable=1, test_mode=1.
  - Counter increments each cycle.
  - When counter==PATTERN_COUNT-1 at the edge -> COMPARE.
  - Exactly PATTERN_COUNT RUN cycles.
- COMPARE, one cycle: test_mode=1, tpg_enable=0. At the edge: sig_captured<=signature, pass<=(signature==GOLDEN_SIG), fail<=~that -> DONE.
- DONE: done=1. pass/fail/sig_captured held until next start, abort or reset. start=1 -> CLEAR, and pass/fail clear to 0 on that edge.
- Latency: start sampled at edge 0 -> CLEAR in cycle 1, RUN cycles 2..PATTERN_COUNT+1, COMPARE cycle PATTERN_COUNT+2, done=1 from cycle PATTERN_COUNT+3 (11 for default).
- start while busy: ignored.
- abort=1 in any state: -> IDLE next edge; pass, fail and counter cleared; sig_captured retained.
- abort and start simultaneous: abort wins.
- PATTERN_COUNT=1: a single RUN cycle.
- Counter width: $clog2(PATTERN_COUNT+1); no wrap reachable.
- pass and fail are never both 1; both 0 outside DONE.
- Async reset mid-RUN: immediate return to reset values; MISR also cleared via system reset.

Decomposition:
- Shared package bist_pkg: state enum (IDLE, CLEAR, RUN, COMPARE, DONE), SIG_WIDTH default constant, default PATTERN_COUNT.
- One natural sub-module: bist_pattern_counter (clear, enable, terminal-count flag).

Test Plan:
- GOLDEN_SIG=4'hA, PATTERN_COUNT=8; start pulse at edge 0; bench drives signature=4'hA in COMPARE -> tpg_enable high exactly 8 cycles (2..9), done=1 at cycle 11, pass=1, fail=0, sig_captured=4'hA.
- Same run with signature=4'h3 -> done=1 at cycle 11, pass=0, fail=1, sig_captured=4'h3.
- start pulsed again in cycles 3 and 5 during RUN -> ignored; done still at cycle 11, tpg_enable count still 8.
- abort asserted in RUN cycle 4 -> IDLE at cycle 5, busy=0, done=0, pass=fail=0; new start gives full 8-cycle RUN.
- reset deasserted to 0 mid-RUN, then released -> all outputs at reset values immediately; ora_reset_n=1; FSM in IDLE.
- From DONE with pass=1, start -> pass cleared next edge, ora_reset_n=0 for exactly one cycle, second run completes; PATTERN_COUNT=1 build -> done at cycle 4.
